// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - bank of clocked SR flops with conflict mode, minimum-off lockout and edge pulses
module sr_reg_bank #(
   parameter int CHANNELS = 2,
   parameter int PRIORITY = 0,
   parameter int MIN_OFF  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] s,
   input  logic [CHANNELS-1:0] r,
   input  logic                clr,
   output logic [CHANNELS-1:0] q,
   output logic [CHANNELS-1:0] q_rise,
   output logic [CHANNELS-1:0] q_fall,
   output logic [CHANNELS-1:0] blocked
);

   localparam int            CW   = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1) : 1;
   localparam logic [CW-1:0] LOAD = CW'(MIN_OFF);

   logic [CW-1:0]       cnt     [CHANNELS];
   logic [CW-1:0]       cnt_nxt [CHANNELS];
   logic [CHANNELS-1:0] q_nxt;
   logic [CHANNELS-1:0] lock;

   always_comb begin
      q_nxt = q;
      lock  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_nxt[i] = cnt[i];
         lock[i]    = (MIN_OFF != 0) && (cnt[i] != '0);
         if (clr) begin
            q_nxt[i] = 1'b0;
         end else begin
            case ({s[i], r[i]})
               2'b10:   q_nxt[i] = q[i] | ~lock[i];
               2'b01:   q_nxt[i] = 1'b0;
               2'b11: begin
                  case (PRIORITY)
                     0:       q_nxt[i] = 1'b0;
                     1:       q_nxt[i] = q[i] | ~lock[i];
                     2:       q_nxt[i] = q[i];
                     default: q_nxt[i] = q[i] ? 1'b0 : ~lock[i];
                  endcase
               end
               default: q_nxt[i] = q[i];
            endcase
         end
         // Every 1->0 transition restarts the lockout, regardless of its cause.
         if (q[i] && !q_nxt[i]) begin
            cnt_nxt[i] = LOAD;
         end else if (cnt[i] != '0) begin
            cnt_nxt[i] = cnt[i] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q      <= '0;
         q_rise <= '0;
         q_fall <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         q      <= q_nxt;
         q_rise <= q_nxt & ~q;
         q_fall <= ~q_nxt & q;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign blocked = lock;

endmodule
